// File: rtl/store_ctrl_pkg.sv
// store_ctrl_pkg: shared definitions for the store controller.
//   - store instruction IDs (SB/SH/SW) and the "no instruction" ID
//   - ON/OFF single-bit constants
//   - FSM state encoding
//   - is_store_id(): true for the three legal store IDs
package store_ctrl_pkg;

  localparam int INST_ID_LEN = 3;

  localparam logic [INST_ID_LEN-1:0] NONE_ID = 3'd0;
  localparam logic [INST_ID_LEN-1:0] SB_ID   = 3'd1;
  localparam logic [INST_ID_LEN-1:0] SH_ID   = 3'd2;
  localparam logic [INST_ID_LEN-1:0] SW_ID   = 3'd3;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_LO = 2'd1,
    REQ_HI = 2'd2
  } state_e;

  function automatic logic is_store_id(input logic [INST_ID_LEN-1:0] id);
    return (id == SB_ID) || (id == SH_ID) || (id == SW_ID);
  endfunction

endpackage

// File: rtl/store_ctrl_if.sv
// store_ctrl_if: bundles the EX-stage request side, the data-memory write
// side and the status outputs of store_ctrl.
//   slave  modport: the controller (accepts requests, issues memory writes)
//   master modport: the environment (EX stage issuing stores, memory acking)
//
// Handshake rules:
//   Request side: a store transfers on a rising edge where st_valid and
//   st_ready are both 1. st_valid may rise or fall at any time while
//   st_ready is 0; nothing is captured then.
//   Memory side: mem_req, mem_addr, mem_wdata and mem_be are held constant
//   from the first cycle mem_req is 1 until a rising edge where mem_ack is
//   sampled 1. mem_ack is ignored whenever mem_req is 0.
interface store_ctrl_if #(
  parameter int ADDR_W = 32
);
  import store_ctrl_pkg::*;

  logic                   st_valid;
  logic                   st_ready;
  logic [INST_ID_LEN-1:0] instr_id;
  logic [ADDR_W-1:0]      st_addr;
  logic [31:0]            st_data;

  logic                   mem_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_be;
  logic                   mem_ack;

  logic                   st_done;
  logic                   st_err;
  logic                   busy;
  state_e                 dbg_state;

  modport slave (
    input  st_valid, instr_id, st_addr, st_data, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
    output st_done, st_err, busy, dbg_state
  );

  modport master (
    output st_valid, instr_id, st_addr, st_data, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
    input  st_done, st_err, busy, dbg_state
  );

endinterface

// File: rtl/store_lane_gen.sv
// store_lane_gen: combinational byte-lane placement for a store.
//   id        store instruction ID (illegal IDs give an all-zero mask)
//   off       byte offset within the word (address bits [1:0])
//   data      LSB-justified store data
//   mask      8 lane enables over two consecutive words ([3:0] word 0)
//   wide_data 64-bit lane-positioned data ([31:0] word 0)
//   split     1 when any byte lands in word 1
module store_lane_gen
  import store_ctrl_pkg::*;
(
  input  logic [INST_ID_LEN-1:0] id,
  input  logic [1:0]             off,
  input  logic [31:0]            data,
  output logic [7:0]             mask,
  output logic [63:0]            wide_data,
  output logic                   split
);

  logic [3:0]  base;
  logic [31:0] data_m;

  // Bytes beyond the store size are cleared so the unused lanes of the
  // write data are always zero, whatever sits in the upper source bits.
  always_comb begin
    base   = 4'b0000;
    data_m = '0;
    case (id)
      SB_ID: begin
        base   = 4'b0001;
        data_m = {24'b0, data[7:0]};
      end
      SH_ID: begin
        base   = 4'b0011;
        data_m = {16'b0, data[15:0]};
      end
      SW_ID: begin
        base   = 4'b1111;
        data_m = data;
      end
      default: begin
        base   = 4'b0000;
        data_m = '0;
      end
    endcase
  end

  assign mask      = {4'b0000, base} << off;
  assign wide_data = {32'b0, data_m} << {off, 3'b000};
  assign split     = |mask[7:4];

endmodule

// File: rtl/store.sv
// store_ctrl: turns one EX-stage store request into one or two word-aligned
// data-memory writes (two when the access crosses a word boundary).
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         store_ctrl_if slave: request handshake, memory write port,
//               st_done / st_err pulses, busy and FSM debug state
module store_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  store_ctrl_if.slave bus
);

  state_e                 state_q, state_d;
  logic [INST_ID_LEN-1:0] id_q, id_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [7:0]             lane_mask;
  logic [63:0]            lane_data;
  logic                   split;
  logic [ADDR_W-1:0]      word0_addr;

  store_lane_gen u_lane_gen (
    .id        (id_q),
    .off       (addr_q[1:0]),
    .data      (data_q),
    .mask      (lane_mask),
    .wide_data (lane_data),
    .split     (split)
  );

  assign word0_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Next state and capture registers. Requests are only looked at in IDLE,
  // which is exactly when st_ready is 1.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = OFF;
    err_d   = OFF;
    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          id_d   = bus.instr_id;
          addr_d = bus.st_addr;
          data_d = bus.st_data;
          if (is_store_id(bus.instr_id)) state_d = REQ_LO;
          else                           err_d   = ON;
        end
      end
      REQ_LO: begin
        if (bus.mem_ack) begin
          state_d = split ? REQ_HI : IDLE;
          done_d  = !split;
        end
      end
      REQ_HI: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          done_d  = ON;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port is decoded straight from the state register so that an
  // asynchronous reset removes the request without waiting for a clock.
  always_comb begin
    bus.mem_req   = OFF;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'b0000;
    if (state_q == REQ_LO) begin
      bus.mem_req   = ON;
      bus.mem_addr  = word0_addr;
      bus.mem_wdata = lane_data[31:0];
      bus.mem_be    = lane_mask[3:0];
    end else if (state_q == REQ_HI) begin
      bus.mem_req   = ON;
      bus.mem_addr  = word0_addr + ADDR_W'(4);  // wraps at the top of memory
      bus.mem_wdata = lane_data[63:32];
      bus.mem_be    = lane_mask[7:4];
    end
  end

  assign bus.st_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.st_done   = done_q;
  assign bus.st_err    = err_q;
  assign bus.dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= NONE_ID;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= OFF;
      err_q   <= OFF;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
